// File: rtl/sphere_column_gen.sv
// Iterative sphere cross-section generator: fills two panel columns ROWS_PER_CYCLE rows per cycle.
// Optional hollow-shell rendering is enabled by defining SPHERE_SHELL_EN.
module sphere_column_gen #(
   parameter int SCAN_RATE      = 32,
   parameter int NUM_COLS       = 64,
   parameter int NUM_ROWS       = 64,
   parameter int RGB_RES        = 9,
   parameter int ROWS_PER_CYCLE = 4
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    req_valid_in,
   output logic                                    req_ready_out,
   input  logic [$clog2(SCAN_RATE)-1:0]            column_index1_in,
   input  logic [$clog2(SCAN_RATE):0]              column_index2_in,
   input  logic [$clog2(NUM_ROWS):0]               radius_in,
   input  logic [$clog2(NUM_ROWS):0]               thickness_in,
   input  logic [RGB_RES-1:0]                      color_in,
   output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns_out,
   output logic                                    columns_valid_out,
   input  logic                                    columns_ready_in
);

   localparam int IW1      = $clog2(SCAN_RATE);
   localparam int IW2      = IW1 + 1;
   localparam int RW       = $clog2(NUM_ROWS) + 1;
   localparam int CW       = $clog2(NUM_ROWS) + 2;
   localparam int DW       = 2 * CW;
   localparam int CX       = NUM_COLS / 2;
   localparam int CY       = NUM_ROWS / 2;
   localparam int LAST_ROW = NUM_ROWS - ROWS_PER_CYCLE;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_e;

   typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;

   function automatic logic [DW-1:0] sq(input logic [CW-1:0] v);
      return DW'(v) * DW'(v);
   endfunction

   function automatic logic pix_lit(input logic [DW-1:0] d2, input logic [DW-1:0] r2,
                                    input logic [DW-1:0] in2, input logic shell);
      return (d2 <= r2) && (!shell || (d2 > in2));
   endfunction

   state_e             state_q, state_d;
   logic [RW-1:0]      row_q, row_d;
   logic [IW1-1:0]     idx1_q, idx1_d;
   logic [IW2-1:0]     idx2_q, idx2_d;
   logic [RW-1:0]      radius_q, radius_d;
   logic [RGB_RES-1:0] color_q, color_d;
   cols_t              shadow_q, shadow_d;
   cols_t              cols_q, cols_d;
   logic               valid_q, valid_d;
   logic               ready_q, ready_d;

   logic [CW-1:0]      dx1_s, dx2_s;
   logic [DW-1:0]      r2_s, in2_s;
   logic               shell_s;
   logic [RW-1:0]      row_s [ROWS_PER_CYCLE];
   logic [CW-1:0]      dy_s  [ROWS_PER_CYCLE];
   logic               lit1_s[ROWS_PER_CYCLE];
   logic               lit2_s[ROWS_PER_CYCLE];

`ifdef SPHERE_SHELL_EN
   logic [RW-1:0]      thick_q, thick_d;

   always_comb begin
      shell_s = (thick_q != {RW{1'b0}}) && (thick_q < radius_q);
      in2_s   = sq(CW'(radius_q - thick_q));
   end
`else
   logic unused_thickness_s;
   assign unused_thickness_s = ^thickness_in;

   always_comb begin
      shell_s = 1'b0;
      in2_s   = {DW{1'b0}};
   end
`endif

   // Per-request horizontal distances and squared radius.
   always_comb begin
      dx1_s = CW'(CX) - CW'(idx1_q);
      if (CW'(idx2_q) >= CW'(CX)) begin
         dx2_s = CW'(idx2_q) - CW'(CX);
      end else begin
         dx2_s = CW'(CX) - CW'(idx2_q);
      end
      r2_s = sq(CW'(radius_q));
   end

   always_comb begin
      for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
         row_s[i] = row_q + RW'(i);
         if (CW'(row_s[i]) >= CW'(CY)) begin
            dy_s[i] = CW'(row_s[i]) - CW'(CY);
         end else begin
            dy_s[i] = CW'(CY) - CW'(row_s[i]);
         end
         lit1_s[i] = pix_lit(sq(dx1_s) + sq(dy_s[i]), r2_s, in2_s, shell_s);
         lit2_s[i] = pix_lit(sq(dx2_s) + sq(dy_s[i]), r2_s, in2_s, shell_s);
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      idx1_d   = idx1_q;
      idx2_d   = idx2_q;
      radius_d = radius_q;
      color_d  = color_q;
      shadow_d = shadow_q;
      cols_d   = cols_q;
      valid_d  = valid_q;
`ifdef SPHERE_SHELL_EN
      thick_d  = thick_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid_in) begin
               idx1_d   = column_index1_in;
               idx2_d   = column_index2_in;
               radius_d = radius_in;
               color_d  = color_in;
`ifdef SPHERE_SHELL_EN
               thick_d  = thickness_in;
`endif
               shadow_d = '0;
               row_d    = {RW{1'b0}};
               state_d  = S_COMPUTE;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_COMPUTE: begin
            for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
               shadow_d[0][row_s[i][RW-2:0]] = lit1_s[i] ? color_q : {RGB_RES{1'b0}};
               shadow_d[1][row_s[i][RW-2:0]] = lit2_s[i] ? color_q : {RGB_RES{1'b0}};
            end
            row_d = row_q + RW'(ROWS_PER_CYCLE);
            // The final group goes straight to the output together with the rest of the shadow.
            if (row_q == RW'(LAST_ROW)) begin
               cols_d  = shadow_d;
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_COMPUTE;
            end
         end
         S_DONE: begin
            if (columns_ready_in) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         row_q    <= {RW{1'b0}};
         idx1_q   <= {IW1{1'b0}};
         idx2_q   <= {IW2{1'b0}};
         radius_q <= {RW{1'b0}};
         color_q  <= {RGB_RES{1'b0}};
         shadow_q <= '0;
         cols_q   <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
`ifdef SPHERE_SHELL_EN
         thick_q  <= {RW{1'b0}};
`endif
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         idx1_q   <= idx1_d;
         idx2_q   <= idx2_d;
         radius_q <= radius_d;
         color_q  <= color_d;
         shadow_q <= shadow_d;
         cols_q   <= cols_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
`ifdef SPHERE_SHELL_EN
         thick_q  <= thick_d;
`endif
      end
   end

   assign req_ready_out     = ready_q;
   assign columns_out       = cols_q;
   assign columns_valid_out = valid_q;

endmodule

// File: tb/tb_sphere_column_gen.sv
// Self-checking bench for sphere_column_gen: directed plan cases plus randomized requests
// checked against a per-pixel distance model.
module tb_sphere_column_gen;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     req_valid;
   logic                     req_ready;
   logic [4:0]               idx1;
   logic [5:0]               idx2;
   logic [6:0]               radius;
   logic [6:0]               thick;
   logic [8:0]               color;
   logic [1:0][63:0][8:0]    cols;
   logic                     cols_valid;
   logic                     cols_ready;

   int tests = 0;
   int fails = 0;

   sphere_column_gen dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .req_valid_in      (req_valid),
      .req_ready_out     (req_ready),
      .column_index1_in  (idx1),
      .column_index2_in  (idx2),
      .radius_in         (radius),
      .thickness_in      (thick),
      .color_in          (color),
      .columns_out       (cols),
      .columns_valid_out (cols_valid),
      .columns_ready_in  (cols_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit expired");
   end

   function automatic logic [575:0] model_col(input int dx, input int r, input int t,
                                              input logic [8:0] c);
      logic [575:0] res;
      int dy, d2;
      logic lit;
      res = '0;
      for (int row = 0; row < 64; row++) begin
         dy  = (row >= 32) ? row - 32 : 32 - row;
         d2  = dx * dx + dy * dy;
         lit = (d2 <= r * r);
`ifdef SPHERE_SHELL_EN
         if (t != 0 && t < r) lit = lit && (d2 > (r - t) * (r - t));
`endif
         res[row*9 +: 9] = lit ? c : 9'h000;
      end
      return res;
   endfunction

   function automatic int lit_rows(input logic [575:0] v);
      int n = 0;
      for (int row = 0; row < 64; row++) if (v[row*9 +: 9] != 9'h000) n++;
      return n;
   endfunction

   task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_col(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, check latency and contents, hold for ready_delay cycles, then release.
   task automatic run_req(input string tag, input int i1, input int i2, input int r, input int t,
                          input logic [8:0] c, input int ready_delay,
                          output logic [575:0] e1, output logic [575:0] e2);
      int lat;
      e1 = model_col(32 - i1, r, t, c);
      e2 = model_col((i2 >= 32) ? i2 - 32 : 32 - i2, r, t, c);
      lat = 0;
      while (!req_ready && lat < 100) begin
         tick();
         lat++;
      end
      check_int({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      idx1 = 5'(i1); idx2 = 6'(i2); radius = 7'(r); thick = 7'(t); color = c;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cols_valid && lat < 40);
      check_int({tag, "_latency"}, 32'(lat), 32'd16);
      check_col({tag, "_col1"}, cols[0], e1);
      check_col({tag, "_col2"}, cols[1], e2);
      check_int({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      repeat (ready_delay) tick();
      check_int({tag, "_valid_held"}, 32'(cols_valid), 32'd1);
      cols_ready = 1'b1;
      tick();
      cols_ready = 1'b0;
      check_int({tag, "_valid_drop"}, 32'(cols_valid), 32'd0);
      check_int({tag, "_ready_back"}, 32'(req_ready), 32'd1);
      check_col({tag, "_col1_kept"}, cols[0], e1);
   endtask

   initial begin
      logic [575:0] e1, e2;
      int lat;
      rst = 1'b1; req_valid = 1'b0; cols_ready = 1'b0;
      idx1 = 5'd0; idx2 = 6'd0; radius = 7'd0; thick = 7'd0; color = 9'h000;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_int("rst_valid", 32'(cols_valid), 32'd0);
      check_int("rst_ready", 32'(req_ready), 32'd1);
      check_col("rst_col1", cols[0], 576'd0);
      check_col("rst_col2", cols[1], 576'd0);

      // Edge columns: single pixel on column 1, rows 25..39 on column 2
      run_req("edge", 0, 63, 32, 0, 9'h1FF, 0, e1, e2);
      check_int("edge_col1_count", 32'(lit_rows(cols[0])), 32'd1);
      check_int("edge_col1_row32", 32'(cols[0][32]), 32'h1FF);
      check_int("edge_col2_count", 32'(lit_rows(cols[1])), 32'd15);
      check_int("edge_col2_row25", 32'(cols[1][25]), 32'h1FF);
      check_int("edge_col2_row24", 32'(cols[1][24]), 32'h000);

      // Near-centre columns
      run_req("centre", 31, 32, 32, 0, 9'h049, 2, e1, e2);
      check_int("centre_col1_row0", 32'(cols[0][0]), 32'h000);
      check_int("centre_col1_count", 32'(lit_rows(cols[0])), 32'd63);
      check_int("centre_col2_count", 32'(lit_rows(cols[1])), 32'd64);

      // Radius zero lights only the centre pixel of column 2
      run_req("r0", 5, 32, 0, 0, 9'h0AA, 0, e1, e2);
      check_int("r0_col2_count", 32'(lit_rows(cols[1])), 32'd1);
      check_int("r0_col2_row32", 32'(cols[1][32]), 32'h0AA);

      // Oversize radius lights everything
      run_req("rbig", 0, 0, 100, 0, 9'h155, 0, e1, e2);
      check_int("rbig_count", 32'(lit_rows(cols[0]) + lit_rows(cols[1])), 32'd128);

      // Backpressure with a competing request held high
      e1 = model_col(12, 20, 0, 9'h0F0);
      e2 = model_col(8, 20, 0, 9'h0F0);
      idx1 = 5'd20; idx2 = 6'd40; radius = 7'd20; thick = 7'd0; color = 9'h0F0;
      req_valid = 1'b1;
      tick();
      idx1 = 5'd3; idx2 = 6'd50; radius = 7'd5; color = 9'h00F;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cols_valid && lat < 40);
      check_int("bp_latency", 32'(lat), 32'd16);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_int("bp_valid", 32'(cols_valid), 32'd1);
         check_int("bp_ready", 32'(req_ready), 32'd0);
         check_col("bp_col1", cols[0], e1);
         check_col("bp_col2", cols[1], e2);
      end
      req_valid = 1'b0;
      cols_ready = 1'b1;
      tick();
      cols_ready = 1'b0;
      check_int("bp_release_valid", 32'(cols_valid), 32'd0);
      check_int("bp_release_ready", 32'(req_ready), 32'd1);
      check_col("bp_release_col2", cols[1], e2);

      // Reset five cycles into COMPUTE
      idx1 = 5'd10; idx2 = 6'd33; radius = 7'd30; color = 9'h111;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_int("midrst_valid", 32'(cols_valid), 32'd0);
      check_int("midrst_ready", 32'(req_ready), 32'd1);
      check_col("midrst_col1", cols[0], 576'd0);
      check_col("midrst_col2", cols[1], 576'd0);
      repeat (20) tick();
      check_int("midrst_no_output", 32'(cols_valid), 32'd0);
      run_req("after_rst", 10, 33, 30, 0, 9'h111, 1, e1, e2);

`ifdef SPHERE_SHELL_EN
      run_req("shell_t2", 0, 32, 10, 2, 9'h1C3, 0, e1, e2);
      check_int("shell_t2_count", 32'(lit_rows(cols[1])), 32'd4);
      check_int("shell_t2_row22", 32'(cols[1][22]), 32'h1C3);
      check_int("shell_t2_row24", 32'(cols[1][24]), 32'h000);
      run_req("shell_t0", 0, 32, 10, 0, 9'h1C3, 0, e1, e2);
      check_int("shell_t0_count", 32'(lit_rows(cols[1])), 32'd21);
`endif

      // Randomized requests
      for (int n = 0; n < 12; n++) begin
         run_req($sformatf("rand%0d", n), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 80)), int'($urandom_range(0, 20)),
                 9'($urandom_range(1, 511)), int'($urandom_range(0, 3)), e1, e2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sphere_column_gen.md
# sphere_column_gen

Sequential, parametrised generator of sphere cross-section column pairs for the rotating-panel volumetric display. It accepts a pair of column indices, plus a runtime radius and colour, over a valid/ready handshake. It evaluates rows iteratively, ROWS_PER_CYCLE at a time, and presents the two finished columns on a registered, back-pressurable output to the panel scan logic.

## Interface
- SCAN_RATE, 32: panel scan rate; sets the index widths.
- NUM_COLS, 64: panel columns; CENTER_X = NUM_COLS/2.
- NUM_ROWS, 64: panel rows; CENTER_Y = NUM_ROWS/2.
- RGB_RES, 9: bits per pixel.
- ROWS_PER_CYCLE, 4: rows evaluated per compute cycle; must divide NUM_ROWS. N = NUM_ROWS/ROWS_PER_CYCLE.
- clk_in  input  1: sole clock, rising edge.
- rst_in  input  1: reset, synchronous, active-high.
- req_valid_in  input  1: request present.
- req_ready_out  output  1: block can accept a request.
- column_index1_in  input  $clog2(SCAN_RATE): first column index, always < CENTER_X.
- column_index2_in  input  $clog2(SCAN_RATE)+1: second column index.
- radius_in  input  $clog2(NUM_ROWS)+1: sphere radius in pixels.
- thickness_in  input  $clog2(NUM_ROWS)+1: shell thickness; used only under SPHERE_SHELL_EN.
- color_in  input  RGB_RES: value written to lit pixels.
- columns_out  output  [1:0][NUM_ROWS-1:0][RGB_RES-1:0]: index 0 is column 1, index 1 is column 2.
- columns_valid_out  output  1: columns_out holds a complete result.
- columns_ready_in  input  1: consumer accepts the result.

## Operation
- FSM states are IDLE, COMPUTE and DONE.
  - IDLE: req_ready_out=1. On req_valid_in && req_ready_out, latch the indices, radius_in, thickness_in and color_in, clear the shadow buffer, set row=0, and go to COMPUTE.
  - COMPUTE: req_ready_out=0. Each cycle, evaluate rows row..row+ROWS_PER_CYCLE-1 for both columns into the shadow buffer, then row += ROWS_PER_CYCLE. After the group containing row NUM_ROWS-1, copy the shadow buffer to columns_out, set columns_valid_out=1, and go to DONE.
  - DONE: columns_out and columns_valid_out are held stable. On columns_ready_in=1, clear columns_valid_out and go to IDLE; columns_out keeps its last value.
- Arithmetic: all unsigned with absolute differences, and no wrap.
  - dx1 = CENTER_X - idx1.
  - dx2 = |idx2 - CENTER_X|.
  - dy = |row - CENTER_Y|.
  - d2 = dx*dx + dy*dy, computed at width 2*($clog2(NUM_ROWS)+2), which is enough for the corner case with no truncation.
  - R2 = radius*radius at the same width.
- Filled rule: a pixel is lit, taking color_in, iff d2 <= R2; otherwise it is 0.
- Radius 0 lights only pixels with d2 = 0.
- A radius larger than the panel is legal; every pixel with d2 <= R2 is lit.
- Requests during COMPUTE or DONE are not accepted; req_valid_in may stay high.
- Reset (any state, including mid-COMPUTE): the next state is IDLE, columns_out=0, columns_valid_out=0, req_ready_out=1, and the in-flight request is discarded.

## Timing
- Reset values: columns_out=0, columns_valid_out=0, req_ready_out=1, state IDLE.
- Latency: if a request is accepted at edge k, columns_valid_out and the new columns_out both appear after edge k+N. With the defaults N=16.
- Throughput: one result per N+2 cycles when the consumer is always ready. req_ready_out rises the cycle after the output transfer, and there is no same-cycle accept-and-release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SPHERE_SHELL_EN defined:
  - Let T = thickness_in and R = radius. A pixel is lit iff d2 <= R2 and (T == 0, or T >= R, or d2 > (R-T)*(R-T)).
  - T = 0 or T >= R degenerates to the filled rule.
- SPHERE_SHELL_EN undefined: the filled rule only. thickness_in is ignored and its latch and compare logic are not built.

## Test plan
- Reset: assert rst_in for 2 cycles -> columns_out=0, columns_valid_out=0, req_ready_out=1.
- idx1=0, idx2=63, R=32, color 9'h1FF -> column 1 lit only at row 32; column 2 lit at rows 25..39. columns_valid_out rises 16 cycles after acceptance.
- idx1=31, idx2=32, R=32, color 9'h049 -> column 1 lit at rows 1..63 (row 0 unlit); column 2 lit at rows 0..63.
- Backpressure: hold columns_ready_in=0 for 10 cycles in DONE while req_valid_in=1 with new indices -> columns_out and valid stay stable, req_ready_out=0, and no new request is taken. Releasing ready returns the block to IDLE next cycle.
- Reset 5 cycles into COMPUTE -> the following cycle shows the IDLE state, columns_out=0, and valid=0. A fresh request then completes normally.
- With SPHERE_SHELL_EN: idx2=32, R=10, T=2 -> column 2 lit only at rows 22, 23, 41, 42. With T=0 the same request lights rows 22..42.
